// File: rtl/ats_eligibility_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ats_eligibility_arbiter_pkg
//   Shared definitions for the ATS transmission-selection arbiter:
//   - grant FSM state encoding (ARBITRATE = 0, PASS = 1)
//   - default timestamp / timer width
//   - clog2 helper with a floor of 1, used to size the queue-ID output
// ----------------------------------------------------------------------------
package ats_eligibility_arbiter_pkg;

  typedef enum logic {
    ST_ARBITRATE = 1'b0,
    ST_PASS      = 1'b1
  } arb_state_t;

  localparam int DEFAULT_TIMESTAMP_WIDTH = 72;

  // Ceiling log2, never less than 1 so a single-queue build still has a
  // one-bit queue-ID field.
  function automatic int clog2_min1(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/ats_eligibility_arbiter_head.sv
// ----------------------------------------------------------------------------
// ats_eligibility_arbiter_head
//   One queue's head register: holds the eligibility timestamp of the next
//   frame, runs the timestamp valid/ready handshake and reports whether the
//   frame is eligible against the shared transmission-selection timer.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   timer        delay-compensated transmission-selection timer
//   ts_tdata     eligibility timestamp of the next frame
//   ts_tvalid    timestamp valid (from the eligibility-time assigner)
//   ts_tready    timestamp ready; high whenever the head is empty
//   clear        frame's last beat accepted downstream; empties the head
//   head_valid   head register holds a timestamp
//   eligible     head_valid and timestamp strictly below the timer
//
// Handshake: a timestamp transfers on a cycle where ts_tvalid && ts_tready
// are both high at the rising edge; ts_tvalid is not required to wait for
// ts_tready, and ts_tready never depends on ts_tvalid.
// ----------------------------------------------------------------------------
module ats_eligibility_arbiter_head
  import ats_eligibility_arbiter_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH = DEFAULT_TIMESTAMP_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TIMESTAMP_WIDTH-1:0] timer,
  input  logic [TIMESTAMP_WIDTH-1:0] ts_tdata,
  input  logic                       ts_tvalid,
  output logic                       ts_tready,
  input  logic                       clear,
  output logic                       head_valid,
  output logic                       eligible
);

  logic [TIMESTAMP_WIDTH-1:0] head_ts;
  logic                       ts_load;

  // The head stays occupied for the whole frame, so a new timestamp for this
  // queue can only land after the frame's last beat has cleared it.
  assign ts_tready = !head_valid && !rst;
  assign ts_load   = ts_tvalid && ts_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
    end else if (ts_load) begin
      head_valid <= 1'b1;
    end else if (clear) begin
      head_valid <= 1'b0;
    end
  end

  // Only meaningful while head_valid is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (ts_load) begin
      head_ts <= ts_tdata;
    end
  end

  // Unsigned, strictly-less-than: a timestamp equal to the timer waits one
  // more tick. The timer is wide enough never to wrap in service.
  assign eligible = head_valid && (head_ts < timer);

endmodule

// File: rtl/ats_eligibility_arbiter.sv
// ----------------------------------------------------------------------------
// ats_eligibility_arbiter
//   Multi-queue transmission-selection scheduler for the ATS egress path.
//   Each queue owns a head register with the eligibility time of its next
//   frame; the highest-priority eligible queue (lowest index) is granted the
//   egress port for one whole frame, with no preemption.
//
// Ports:
//   clk, rst                              clock, sync active-high reset
//   transmission_selection_timer_with_delay  shared timer (delay included)
//   s_axis_tdata/tkeep/tvalid/tlast       per-queue frame streams (flattened)
//   s_axis_tready                         per-queue ready
//   s_axis_eligibility_timestamp_tdata    per-queue next-frame eligibility time
//   s_axis_eligibility_timestamp_tvalid   per-queue timestamp valid
//   s_axis_eligibility_timestamp_tready   per-queue timestamp ready
//   m_axis_tdata/tkeep/tvalid/tlast       egress stream to the MAC
//   m_axis_tready                         egress ready
//   m_axis_tuser                          queue ID of the granted frame
//   busy                                  grant FSM is in PASS
//
// Handshake: every stream transfers a beat on a rising edge where its valid
// and ready are both high. Valid never waits on ready; the egress ready is
// passed combinationally to the granted queue only, with no buffering.
// ----------------------------------------------------------------------------
module ats_eligibility_arbiter
  import ats_eligibility_arbiter_pkg::*;
#(
  parameter int NUM_QUEUES         = 4,
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
  parameter int TIMESTAMP_WIDTH    = DEFAULT_TIMESTAMP_WIDTH,
  parameter int QID_WIDTH          = clog2_min1(NUM_QUEUES)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [TIMESTAMP_WIDTH-1:0]               transmission_selection_timer_with_delay,
  input  logic [NUM_QUEUES*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_QUEUES*C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_QUEUES-1:0]                    s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                    s_axis_tlast,
  output logic [NUM_QUEUES-1:0]                    s_axis_tready,
  input  logic [NUM_QUEUES*TIMESTAMP_WIDTH-1:0]    s_axis_eligibility_timestamp_tdata,
  input  logic [NUM_QUEUES-1:0]                    s_axis_eligibility_timestamp_tvalid,
  output logic [NUM_QUEUES-1:0]                    s_axis_eligibility_timestamp_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]            m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                                     m_axis_tvalid,
  output logic                                     m_axis_tlast,
  input  logic                                     m_axis_tready,
  output logic [QID_WIDTH-1:0]                     m_axis_tuser,
  output logic                                     busy
);

  arb_state_t            state;
  arb_state_t            state_next;
  logic [QID_WIDTH-1:0]  grant_reg;
  logic [QID_WIDTH-1:0]  grant_next;
  logic [QID_WIDTH-1:0]  pick_idx;
  logic                  any_eligible;
  logic                  last_accept;
  logic [NUM_QUEUES-1:0] head_valid;
  logic [NUM_QUEUES-1:0] eligible;
  logic [NUM_QUEUES-1:0] head_clear;

  // --------------------------------------------------------------------------
  // Per-queue head registers
  // --------------------------------------------------------------------------
  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_head
    ats_eligibility_arbiter_head #(
      .TIMESTAMP_WIDTH (TIMESTAMP_WIDTH)
    ) u_head (
      .clk        (clk),
      .rst        (rst),
      .timer      (transmission_selection_timer_with_delay),
      .ts_tdata   (s_axis_eligibility_timestamp_tdata[q*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH]),
      .ts_tvalid  (s_axis_eligibility_timestamp_tvalid[q]),
      .ts_tready  (s_axis_eligibility_timestamp_tready[q]),
      .clear      (head_clear[q]),
      .head_valid (head_valid[q]),
      .eligible   (eligible[q])
    );

    assign head_clear[q] = last_accept && (grant_reg == QID_WIDTH'(q));
  end

  // --------------------------------------------------------------------------
  // Priority encoder: lowest eligible index wins. Scanning downward lets the
  // last assignment (lowest index) take precedence.
  // --------------------------------------------------------------------------
  always_comb begin
    pick_idx     = '0;
    any_eligible = |eligible;
    for (int q = NUM_QUEUES - 1; q >= 0; q--) begin
      if (eligible[q]) pick_idx = QID_WIDTH'(q);
    end
  end

  // --------------------------------------------------------------------------
  // Egress mux. Data/keep/last always follow grant_reg; only valid and the
  // ready fan-out are gated by the FSM, so ARBITRATE shows don't-care data.
  // --------------------------------------------------------------------------
  always_comb begin
    m_axis_tdata  = s_axis_tdata[int'(grant_reg)*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
    m_axis_tkeep  = s_axis_tkeep[int'(grant_reg)*C_AXIS_TKEEP_WIDTH +: C_AXIS_TKEEP_WIDTH];
    m_axis_tlast  = s_axis_tlast[grant_reg];
    m_axis_tvalid = (state == ST_PASS) && s_axis_tvalid[grant_reg];
    s_axis_tready = '0;
    if (state == ST_PASS) begin
      s_axis_tready[grant_reg] = m_axis_tready;
    end
  end

  assign last_accept = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // --------------------------------------------------------------------------
  // Grant FSM. Eligibility is looked at only in ARBITRATE; once a frame is
  // granted it runs to tlast regardless of the timer or other queues.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    grant_next = grant_reg;
    case (state)
      ST_ARBITRATE: begin
        if (any_eligible) begin
          grant_next = pick_idx;
          state_next = ST_PASS;
        end
      end
      ST_PASS: begin
        if (last_accept) begin
          state_next = ST_ARBITRATE;
        end
      end
      default: begin
        state_next = ST_ARBITRATE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ARBITRATE;
      grant_reg <= '0;
    end else begin
      state     <= state_next;
      grant_reg <= grant_next;
    end
  end

  assign m_axis_tuser = grant_reg;
  assign busy         = (state == ST_PASS);

endmodule

// File: tb/tb_ats_eligibility_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ats_eligibility_arbiter
//   Directed bench for ats_eligibility_arbiter (4 queues, 8-bit data,
//   72-bit timestamps). Per-queue sources feed frames from bench queues; every
//   beat a frame will carry is pushed to exp_q in the order the queues are
//   expected to be granted, and the egress monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_ats_eligibility_arbiter;

  localparam int NQ = 4;
  localparam int DW = 8;
  localparam int KW = 1;
  localparam int TW = 72;
  localparam int QW = 2;
  localparam int SW = KW + 1 + DW;      // source beat word {keep, last, data}
  localparam int EW = QW + SW;          // expected beat {qid, keep, last, data}

  // --------------------------------------------------------------------------
  // DUT signals
  // --------------------------------------------------------------------------
  logic             clk;
  logic             rst;
  logic [TW-1:0]    timer;
  logic [NQ*DW-1:0] s_axis_tdata;
  logic [NQ*KW-1:0] s_axis_tkeep;
  logic [NQ-1:0]    s_axis_tvalid;
  logic [NQ-1:0]    s_axis_tlast;
  logic [NQ-1:0]    s_axis_tready;
  logic [NQ*TW-1:0] ets_tdata;
  logic [NQ-1:0]    ets_tvalid;
  logic [NQ-1:0]    ets_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic [KW-1:0]    m_axis_tkeep;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready;
  logic [QW-1:0]    m_axis_tuser;
  logic             busy;

  ats_eligibility_arbiter #(
    .NUM_QUEUES         (NQ),
    .C_AXIS_TDATA_WIDTH (DW),
    .C_AXIS_TKEEP_WIDTH (KW),
    .TIMESTAMP_WIDTH    (TW),
    .QID_WIDTH          (QW)
  ) dut (
    .clk                                     (clk),
    .rst                                     (rst),
    .transmission_selection_timer_with_delay (timer),
    .s_axis_tdata                            (s_axis_tdata),
    .s_axis_tkeep                            (s_axis_tkeep),
    .s_axis_tvalid                           (s_axis_tvalid),
    .s_axis_tlast                            (s_axis_tlast),
    .s_axis_tready                           (s_axis_tready),
    .s_axis_eligibility_timestamp_tdata      (ets_tdata),
    .s_axis_eligibility_timestamp_tvalid     (ets_tvalid),
    .s_axis_eligibility_timestamp_tready     (ets_tready),
    .m_axis_tdata                            (m_axis_tdata),
    .m_axis_tkeep                            (m_axis_tkeep),
    .m_axis_tvalid                           (m_axis_tvalid),
    .m_axis_tlast                            (m_axis_tlast),
    .m_axis_tready                           (m_axis_tready),
    .m_axis_tuser                            (m_axis_tuser),
    .busy                                    (busy)
  );

  // --------------------------------------------------------------------------
  // Clock and cycle counter
  // --------------------------------------------------------------------------
  int cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Shared bench state
  // --------------------------------------------------------------------------
  logic [SW-1:0] src_q [NQ][$];   // per-queue upstream FIFO contents
  logic [EW-1:0] exp_q [$];       // scoreboard: beats in expected egress order
  logic          flush_req;       // upstream FIFOs reset along with the DUT
  logic          bp_en;           // toggle m_axis_tready every cycle

  int tb_tests, tb_fail;          // comparisons made by the directed sequence
  int mon_tests, mon_fail;        // comparisons made by the egress monitor
  int n_beats;
  int last_gap;
  int last_end_cyc;
  bit in_frame;

  // --------------------------------------------------------------------------
  // Upstream sources: handshake sampled mid-cycle, FIFOs advanced just after
  // the edge that consumed the beat.
  // --------------------------------------------------------------------------
  initial begin
    logic [NQ-1:0] take;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    forever begin
      @(negedge clk);
      take = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int q = 0; q < NQ; q++) begin
        if (flush_req) src_q[q].delete();
        else if (take[q] && src_q[q].size() > 0) void'(src_q[q].pop_front());
        if (src_q[q].size() > 0) begin
          s_axis_tvalid[q]         = 1'b1;
          s_axis_tdata[q*DW +: DW] = src_q[q][0][DW-1:0];
          s_axis_tlast[q]          = src_q[q][0][DW];
          s_axis_tkeep[q*KW +: KW] = src_q[q][0][DW+1 +: KW];
        end else begin
          s_axis_tvalid[q]         = 1'b0;
          s_axis_tdata[q*DW +: DW] = '0;
          s_axis_tlast[q]          = 1'b0;
          s_axis_tkeep[q*KW +: KW] = '0;
        end
      end
    end
  end

  // Egress ready: steady high, or alternating 1/0 when bp_en is set.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) m_axis_tready = ~m_axis_tready;
      else       m_axis_tready = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Egress monitor / scoreboard
  // --------------------------------------------------------------------------
  initial begin
    logic [EW-1:0] obs;
    logic [EW-1:0] expv;
    logic [NQ-1:0] exp_rdy;
    mon_tests    = 0;
    mon_fail     = 0;
    n_beats      = 0;
    last_gap     = 0;
    last_end_cyc = 0;
    in_frame     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) in_frame = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        n_beats = n_beats + 1;
        obs = {m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tdata};
        mon_tests = mon_tests + 1;
        assert (exp_q.size() != 0) else begin
          mon_fail = mon_fail + 1;
          $error("FAIL unexpected_beat: observed %0h expected no beat", obs);
        end
        if (exp_q.size() != 0) begin
          expv = exp_q.pop_front();
          mon_tests = mon_tests + 1;
          assert (obs === expv) else begin
            mon_fail = mon_fail + 1;
            $error("FAIL beat: observed %0h expected %0h", obs, expv);
          end
          exp_rdy = 4'b0001 << expv[EW-1 -: QW];
          mon_tests = mon_tests + 1;
          assert (s_axis_tready === exp_rdy) else begin
            mon_fail = mon_fail + 1;
            $error("FAIL s_tready_onehot: observed %0b expected %0b", s_axis_tready, exp_rdy);
          end
        end
        if (!in_frame) begin
          last_gap = cyc - last_end_cyc;
          in_frame = 1'b1;
        end
        if (m_axis_tlast) begin
          last_end_cyc = cyc;
          in_frame     = 1'b0;
        end
      end
      if (bp_en && !m_axis_tready) begin
        mon_tests = mon_tests + 1;
        assert (s_axis_tready === 4'b0000) else begin
          mon_fail = mon_fail + 1;
          $error("FAIL s_tready_stall: observed %0b expected 0000", s_axis_tready);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver / check tasks for the directed sequence
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
    tb_tests = tb_tests + 1;
    assert (obs === expv) else begin
      tb_fail = tb_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue a frame at source q and record its beats on the scoreboard.
  task automatic add_frame(input int q, input int nb);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    for (int i = 0; i < nb; i++) begin
      d = DW'($urandom_range(0, 255));
      k = KW'($urandom_range(0, 1));
      l = (i == nb - 1);
      src_q[q].push_back({k, l, d});
      exp_q.push_back({QW'(q), k, l, d});
    end
  endtask

  // Present a timestamp to queue q; returns #1 after the handshake edge.
  task automatic load_ts(input int q, input logic [TW-1:0] ts);
    bit done;
    done = 1'b0;
    ets_tdata[q*TW +: TW] = ts;
    ets_tvalid[q]         = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (ets_tready[q]) done = 1'b1;
      @(posedge clk);
      #1;
    end
    ets_tvalid[q] = 1'b0;
    check("ts_handshake_timeout", done, 1'b1);
  endtask

  // Wait until the scoreboard is empty and the port is idle again.
  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      tick();
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    check(tag, done, 1'b1);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int start;
    bit seen;
    tb_tests   = 0;
    tb_fail    = 0;
    rst        = 1'b1;
    timer      = '0;
    ets_tdata  = '0;
    ets_tvalid = '0;
    flush_req  = 1'b0;
    bp_en      = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_m_tvalid",  m_axis_tvalid, 1'b0);
    check("rst_s_tready",  s_axis_tready, 4'b0000);
    check("rst_ts_tready", ets_tready,    4'b0000);
    check("rst_busy",      busy,          1'b0);
    check("rst_tuser",     m_axis_tuser,  2'd0);
    rst = 1'b0;
    tick();
    check("idle_ts_tready", ets_tready, 4'b1111);

    // Single queue: not eligible at timer 99, granted once the timer passes
    timer = 72'd99;
    add_frame(2, 4);
    load_ts(2, 72'd100);
    repeat (4) tick();
    check("q2_early_busy",     busy,          1'b0);
    check("q2_early_tvalid",   m_axis_tvalid, 1'b0);
    check("q2_head_held",      ets_tready[2], 1'b0);
    timer = 72'd101;
    wait_drain("q2_drain");
    check("q2_ts_tready_back", ets_tready[2], 1'b1);

    // Earliest latency: handshake at t, tvalid at t+2
    timer = 72'd1000;
    add_frame(2, 2);
    tick();
    load_ts(2, 72'd500);
    check("lat_t1_tvalid", m_axis_tvalid, 1'b0);
    tick();
    check("lat_t2_tvalid", m_axis_tvalid, 1'b1);
    check("lat_t2_tuser",  m_axis_tuser,  2'd2);
    check("lat_t2_busy",   busy,          1'b1);
    wait_drain("lat_drain");

    // Priority: q1 and q3 become eligible together; q1 first, one idle cycle
    timer = 72'd0;
    add_frame(1, 3);
    add_frame(3, 3);
    load_ts(1, 72'd50);
    load_ts(3, 72'd10);
    check("prio_wait_busy", busy, 1'b0);
    timer = 72'd100;
    wait_drain("prio_drain");
    check("prio_gap", 32'(last_gap), 32'd2);

    // No preemption: q0 becomes eligible while q3 is mid-frame
    add_frame(3, 6);
    load_ts(3, 72'd10);
    tick();
    check("npre_q3_tuser", m_axis_tuser, 2'd3);
    add_frame(0, 2);
    load_ts(0, 72'd5);
    check("npre_still_q3", m_axis_tuser, 2'd3);
    check("npre_busy",     busy,         1'b1);
    wait_drain("npre_drain");

    // Back-pressure: egress ready alternates across a 6-beat frame
    bp_en = 1'b1;
    add_frame(1, 6);
    load_ts(1, 72'd20);
    wait_drain("bp_drain");
    bp_en = 1'b0;
    tick();

    // Boundary: timestamp equal to the timer is not eligible
    timer = 72'd200;
    add_frame(0, 2);
    load_ts(0, 72'd200);
    repeat (4) tick();
    check("bnd_eq_busy",   busy,          1'b0);
    check("bnd_eq_tvalid", m_axis_tvalid, 1'b0);
    timer = 72'd201;
    tick();
    check("bnd_gt_busy",  busy,         1'b1);
    check("bnd_gt_tuser", m_axis_tuser, 2'd0);
    wait_drain("bnd_drain");

    // Reset in the middle of a 5-beat frame, while beat 3 is on the bus
    timer = 72'd300;
    start = n_beats;
    add_frame(2, 5);
    load_ts(2, 72'd10);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (n_beats >= start + 2) seen = 1'b1;
    end
    check("mid_rst_reach_beat2", seen, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_m_tvalid",  m_axis_tvalid, 1'b0);
    check("mid_rst_s_tready",  s_axis_tready, 4'b0000);
    check("mid_rst_ts_tready", ets_tready,    4'b0000);
    check("mid_rst_busy",      busy,          1'b0);
    check("mid_rst_tuser",     m_axis_tuser,  2'd0);
    check("mid_rst_beats",     32'(n_beats - start), 32'd3);
    exp_q.delete();
    flush_req = 1'b1;
    repeat (2) tick();
    flush_req = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_ts_tready", ets_tready, 4'b1111);
    repeat (3) tick();
    check("post_rst_busy",   busy,          1'b0);
    check("post_rst_tvalid", m_axis_tvalid, 1'b0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tb_tests + mon_tests, tb_fail + mon_fail);
    $finish;
  end

endmodule
